// File: rtl/ccff_pkg.sv
// Shared types and constants for the ccff chain loader: FSM states, CRC-16-CCITT
// constants and a small count helper.
package ccff_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } ccff_state_e;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   function automatic int unsigned min_cnt(input int unsigned a, input int unsigned b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/ccff_tail_crc16.sv
// Serial CRC-16-CCITT (MSB-first) over the bits emerging from ccff_tail.
// Only instantiated when CCFF_TAIL_READBACK_EN is defined.
module ccff_tail_crc16
   import ccff_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_init,
   input  logic        i_sample,
   input  logic        i_bit,
   output logic [15:0] o_crc
);

   logic [15:0] r_crc;
   logic        w_fb;

   assign w_fb = r_crc[15] ^ i_bit;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_init) begin
         r_crc <= CRC16_INIT;
      end else if (i_sample) begin
         r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
      end
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words MSB-first onto the ccff chain and stops after CHAIN_LEN bits.
// Optional macro CCFF_TAIL_READBACK_EN adds readback_sig, a CRC-16 of the bits leaving ccff_tail.
module ccff_chain_loader
   import ccff_pkg::*;
#(
   parameter  int WORD_W    = 8,
   parameter  int CHAIN_LEN = 64,
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
)(
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  bits_left
`ifdef CCFF_TAIL_READBACK_EN
   ,
   output logic [15:0]       readback_sig
`endif
);

   localparam int IDX_W = $clog2(WORD_W + 1);

   ccff_state_e       r_state;
   ccff_state_e       w_state_nxt;

   logic [WORD_W-1:0] r_shreg;
   logic [IDX_W-1:0]  r_bit_idx;
   logic [CNT_W-1:0]  r_bits_left;
   logic              r_head;
   logic              r_shift_en;
   logic              r_busy;
   logic              r_done;

   logic              w_word_ready;
   logic              w_fire;
   logic              w_shift;
   logic              w_load_start;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: default assignment first so no path through the case can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start)      w_state_nxt = FETCH;
         FETCH:   if (word_valid) w_state_nxt = SHIFT;
         SHIFT: begin
            if (r_bits_left == CNT_W'(1))     w_state_nxt = DONE;
            else if (r_bit_idx == IDX_W'(1))  w_state_nxt = FETCH;
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_word_ready = (r_state == FETCH);
      w_fire       = w_word_ready && word_valid;
      w_shift      = (r_state == SHIFT);
      w_load_start = (r_state == IDLE) && start;
   end

   // Datapath: a partial last word only loads bits_left into bit_idx, so its low bits never leave.
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         r_shreg     <= '0;
         r_bit_idx   <= '0;
         r_bits_left <= '0;
         r_head      <= 1'b0;
         r_shift_en  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_shift_en <= w_shift;
         r_done     <= (r_state == DONE);

         if (w_load_start) begin
            r_bits_left <= CNT_W'(CHAIN_LEN);
            r_busy      <= 1'b1;
         end

         if (r_state == DONE) begin
            r_busy <= 1'b0;
         end

         if (w_fire) begin
            r_shreg   <= word_data;
            r_bit_idx <= IDX_W'(min_cnt(WORD_W, 32'(r_bits_left)));
         end

         if (w_shift) begin
            r_head      <= r_shreg[WORD_W-1];
            r_shreg     <= r_shreg << 1;
            r_bits_left <= r_bits_left - CNT_W'(1);
            r_bit_idx   <= r_bit_idx - IDX_W'(1);
         end
      end
   end

   assign word_ready    = w_word_ready;
   assign ccff_head     = r_head;
   assign ccff_shift_en = r_shift_en;
   assign busy          = r_busy;
   assign done          = r_done;
   assign bits_left     = r_bits_left;

`ifdef CCFF_TAIL_READBACK_EN
   ccff_tail_crc16 u_tail_crc (
      .i_clk    (prog_clk),
      .i_rst    (pReset),
      .i_init   (w_load_start),
      .i_sample (r_shift_en),
      .i_bit    (ccff_tail),
      .o_crc    (readback_sig)
   );
`else
   logic w_unused_tail;
   assign w_unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: two instances (CHAIN_LEN 64 and 12), randomized words,
// gaps and stray start pulses, checked against a bit-stream model built from the words.
`timescale 1ns/1ps
module tb_ccff_chain_loader;

   localparam int LEN0 = 64;
   localparam int LEN1 = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_s   [2];
   logic       start_s [2];
   logic       valid_s [2];
   logic       tail_s  [2];
   logic [7:0] data_s  [2];
   wire        ready_w [2];
   wire        head_w  [2];
   wire        sen_w   [2];
   wire        busy_w  [2];
   wire        done_w  [2];
   wire [6:0]  bl0;
   wire [3:0]  bl1;
`ifdef CCFF_TAIL_READBACK_EN
   wire [15:0] rb_w [2];
`endif

   ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(LEN0)) u_dut0 (
      .prog_clk(clk), .pReset(rst_s[0]), .start(start_s[0]), .word_data(data_s[0]),
      .word_valid(valid_s[0]), .word_ready(ready_w[0]), .ccff_head(head_w[0]),
      .ccff_shift_en(sen_w[0]), .ccff_tail(tail_s[0]), .busy(busy_w[0]), .done(done_w[0]),
      .bits_left(bl0)
`ifdef CCFF_TAIL_READBACK_EN
      , .readback_sig(rb_w[0])
`endif
   );

   ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(LEN1)) u_dut1 (
      .prog_clk(clk), .pReset(rst_s[1]), .start(start_s[1]), .word_data(data_s[1]),
      .word_valid(valid_s[1]), .word_ready(ready_w[1]), .ccff_head(head_w[1]),
      .ccff_shift_en(sen_w[1]), .ccff_tail(tail_s[1]), .busy(busy_w[1]), .done(done_w[1]),
      .bits_left(bl1)
`ifdef CCFF_TAIL_READBACK_EN
      , .readback_sig(rb_w[1])
`endif
   );

   int   n_vec = 0;
   int   n_err = 0;
   int   len_c      [2];
   bit   exp_q      [2][$];
   bit   tail_hist  [2][$];
   int   sh_cnt     [2];
   int   bub        [2];
   int   done_cnt   [2];
   int   model_left [2];
   bit   seen       [2];
   bit   prev_done  [2];
   bit   mon_en     [2];
   bit   tail_rand;
   logic [7:0] wq [$];

   task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", nm, k, act, exp, $time);
      end
   endtask

   function automatic int get_bl(input int k);
      return (k == 0) ? int'(bl0) : int'(bl1);
   endfunction

   // CRC-16-CCITT, MSB-first, init 0xFFFF over a list of bits.
   function automatic logic [15:0] crc_of(input bit b[$]);
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (b[i]) c = (c[15] ^ b[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
      return c;
   endfunction

   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 2; k++) tail_s[k] = tail_rand ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   // Monitor: pops one expected head bit per shift_en cycle; checks bits_left and done framing.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (mon_en[k]) begin
            if (sen_w[k]) begin
               sh_cnt[k]++;
               seen[k] = 1'b1;
               tail_hist[k].push_back(tail_s[k]);
               if (exp_q[k].size() == 0) check("unexpected_shift", k, 1, 0);
               else check("ccff_head", k, head_w[k], exp_q[k].pop_front());
               check("bits_left", k, get_bl(k), len_c[k] - sh_cnt[k]);
            end else if (busy_w[k]) begin
               if (seen[k]) bub[k]++;
               check("bits_left_hold", k, get_bl(k), len_c[k] - sh_cnt[k]);
            end
            if (prev_done[k]) check("done_one_cycle", k, done_w[k], 0);
            if (done_w[k]) begin
               done_cnt[k]++;
               check("shift_count", k, sh_cnt[k], len_c[k]);
               check("queue_drained", k, exp_q[k].size(), 0);
               check("busy_at_done", k, busy_w[k], 0);
`ifdef CCFF_TAIL_READBACK_EN
               check("readback", k, rb_w[k], crc_of(tail_hist[k]));
`endif
            end
            prev_done[k] = done_w[k];
         end
      end
   end

   task automatic do_reset(input int k);
      @(posedge clk); #1;
      rst_s[k] = 1'b1; mon_en[k] = 1'b0;
      start_s[k] = 1'b0; valid_s[k] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_word_ready", k, ready_w[k], 0);
      check("rst_ccff_head", k, head_w[k], 0);
      check("rst_shift_en", k, sen_w[k], 0);
      check("rst_busy", k, busy_w[k], 0);
      check("rst_done", k, done_w[k], 0);
      check("rst_bits_left", k, get_bl(k), 0);
      @(posedge clk); #1;
      rst_s[k] = 1'b0;
      exp_q[k].delete(); tail_hist[k].delete();
      sh_cnt[k] = 0; bub[k] = 0; seen[k] = 1'b0; prev_done[k] = 1'b0;
      mon_en[k] = 1'b1;
   endtask

   task automatic begin_load(input int k, input logic [7:0] first);
      exp_q[k].delete(); tail_hist[k].delete();
      sh_cnt[k] = 0; bub[k] = 0; seen[k] = 1'b0;
      model_left[k] = len_c[k];
      @(posedge clk); #1;
      start_s[k] = 1'b1; valid_s[k] = 1'b1; data_s[k] = first;
      @(posedge clk); #1;
      start_s[k] = 1'b0;
   endtask

   // Offers a word until accepted, then appends its surviving bits to the expected stream.
   task automatic feed_word(input int k, input logic [7:0] d);
      int n;
      valid_s[k] = 1'b1; data_s[k] = d;
      @(negedge clk);
      for (int t = 0; t < 100 && !ready_w[k]; t++) @(negedge clk);
      check("handshake", k, ready_w[k], 1);
      n = (model_left[k] < 8) ? model_left[k] : 8;
      for (int i = 0; i < n; i++) exp_q[k].push_back(d[7-i]);
      model_left[k] -= n;
      @(posedge clk); #1;
      valid_s[k] = 1'b0;
   endtask

   task automatic run_load(input int k, input bit rnd_gap, input int stall_w, input int stall_len);
      int d0;
      int gap;
      d0 = done_cnt[k];
      begin_load(k, wq[0]);
      for (int w = 0; w < wq.size(); w++) begin
         gap = (w == 0) ? 0 : (rnd_gap ? $urandom_range(0, 12) : ((w == stall_w) ? stall_len : 0));
         for (int g = 0; g < gap; g++) begin
            valid_s[k] = 1'b0;
            if (rnd_gap && $urandom_range(0, 3) == 0) start_s[k] = 1'b1;
            @(posedge clk); #1;
            start_s[k] = 1'b0;
         end
         feed_word(k, wq[w]);
      end
      for (int t = 0; t < 300 && done_cnt[k] == d0; t++) @(negedge clk);
      check("done_count", k, done_cnt[k] - d0, 1);
      @(negedge clk);
      check("busy_after", k, busy_w[k], 0);
`ifdef CCFF_TAIL_READBACK_EN
      repeat (3) @(negedge clk);
      check("readback_frozen", k, rb_w[k], crc_of(tail_hist[k]));
`endif
   endtask

   task automatic fill_random(input int n);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      len_c[0] = LEN0; len_c[1] = LEN1;
      tail_rand = 1'b0;
      for (int k = 0; k < 2; k++) begin
         rst_s[k] = 1'b1; start_s[k] = 1'b0; valid_s[k] = 1'b0; data_s[k] = 8'h00;
         mon_en[k] = 1'b0; done_cnt[k] = 0; prev_done[k] = 1'b0;
      end
      do_reset(0);
      do_reset(1);

      // 8 x 0xA5 with valid held high; tail held 0.
      wq.delete();
      for (int i = 0; i < 8; i++) wq.push_back(8'hA5);
      run_load(0, 1'b0, -1, 0);
      check("bubbles_held_valid", 0, bub[0], 7);

      // Short chain, partial second word.
      wq = {8'hFF, 8'hF0};
      run_load(1, 1'b0, -1, 0);
      check("bubbles_short", 1, bub[1], 1);

      // 13 idle cycles after a handshake: 8 land in SHIFT, 5 stall FETCH.
      tail_rand = 1'b1;
      fill_random(8);
      run_load(0, 1'b0, 3, 13);
      check("bubbles_stall", 0, bub[0], 12);

      // Reset after 20 bits, then a full reload.
      fill_random(3);
      begin_load(0, wq[0]);
      for (int w = 0; w < 3; w++) feed_word(0, wq[w]);
      for (int t = 0; t < 100 && sh_cnt[0] < 20; t++) @(negedge clk);
      check("reached_20_bits", 0, (sh_cnt[0] >= 20), 1);
      do_reset(0);
      fill_random(8);
      run_load(0, 1'b0, -1, 0);

      // Random gaps and stray start pulses.
      for (int r = 0; r < 3; r++) begin
         fill_random(8);
         run_load(0, 1'b1, -1, 0);
         fill_random(2);
         run_load(1, 1'b1, -1, 0);
      end

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
Sequences the configuration-flip-flop (ccff) chain that threads through the io and logic tiles: ccff_head -> tile chains -> ccff_tail. It accepts bitstream words over a valid/ready interface and serializes them MSB-first onto ccff_head. It generates the per-cycle shift enable used to gate prog_clk into the chain, and it stops after exactly CHAIN_LEN bits. It sits between the programming interface (wishbone/logic-analyzer side) and the fabric's top-level ccff_head/ccff_tail.

Parameters:
- WORD_W, 8, width of each bitstream word.
- CHAIN_LEN, 64, total ccff bits in the chain (8 io subtiles × 8 bits default); must be ≥1.
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter (localparam).

Ports:
- prog_clk  in  1  programming clock; all state on rising edge.
- pReset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load when IDLE, ignored otherwise.
- word_data  in  WORD_W  bitstream word, MSB shifted first.
- word_valid  in  1  word_data valid.
- word_ready  out  1  loader accepts word this cycle.
- ccff_head  out  1  serial bit to chain head (registered).
- ccff_shift_en  out  1  chain clock-gate enable; chain captures ccff_head on the edge where this is 1 (registered).
- ccff_tail  in  1  chain tail (previous contents emerge here).
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last bit is shifted.
- bits_left  out  CNT_W  remaining bits to shift.

Behaviour:
- Reset values: word_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, bits_left=0; FSM=IDLE; shift register cleared.
- FSM states are IDLE, FETCH, SHIFT, DONE.
- IDLE: on start, bits_left<=CHAIN_LEN, busy<=1, go to FETCH. If start and word_valid arrive in the same cycle, the word is not consumed.
- FETCH: word_ready=1, combinational from state. On word_valid&&word_ready:
  - load shreg<=word_data;
  - bit_idx<=min(WORD_W, bits_left);
  - go to SHIFT.
  - Without valid, stay in FETCH with ccff_shift_en=0; the chain holds.
- SHIFT: each cycle, ccff_head<=shreg[MSB], shreg<<=1, ccff_shift_en<=1, bits_left--, bit_idx--.
  - When bit_idx hits 1 and bits_left>1: go to FETCH. This leaves a one-cycle bubble with shift_en=0.
  - When bits_left hits 1: go to DONE.
- Partial last word: if bits_left<WORD_W at fetch, only the upper bits_left bits are shifted and the low bits are discarded.
- DONE: ccff_shift_en<=0, done=1 for one cycle, busy<=0, return to IDLE.
- Total shift_en-high cycles per load = CHAIN_LEN exactly, regardless of WORD_W divisibility.
- Latency: the first ccff_shift_en is asserted 2 cycles after the accepted word handshake; ccff_head is valid in the same cycle as its shift_en.
- start while busy: ignored (no restart, no error).
- pReset mid-load: all outputs return to their reset values next cycle. The chain is left partially loaded; the host must restart.
- word_valid outside FETCH: ignored, no ready.

Optional Feature:
- Macro CCFF_TAIL_READBACK_EN adds output readback_sig [15:0].
  - Holds a CRC-16-CCITT (poly 0x1021, init 0xFFFF) of every ccff_tail bit sampled on cycles where ccff_shift_en=1.
  - Reset to 0xFFFF on start; frozen after done.
  - Lets the host verify the prior chain contents.
- Without the macro: no port, no CRC logic; ccff_tail is unused.

Decomposition:
- Shared package ccff_pkg holds:
  - FSM state enum (IDLE/FETCH/SHIFT/DONE);
  - CRC16 polynomial/init constants;
  - a function for min-of-two counts.
- One natural sub-module: ccff_tail_crc16, the serial CRC, instantiated only under CCFF_TAIL_READBACK_EN.

Test Plan:
- Reset then start, 8 words 0xA5 with valid held high -> 64 shift_en cycles, ccff_head sequence 10100101 repeated, 7 one-cycle bubbles, done pulses once, busy low after.
- CHAIN_LEN=12, words 0xFF,0xF0 -> exactly 12 shift_en cycles, head bits 1111_1111_1111, low nibble of the second word discarded.
- Valid deasserted 5 cycles in FETCH -> shift_en stays 0 and bits_left is constant; resumes correctly.
- start pulsed during SHIFT -> ignored; bits_left continues its decrement sequence unchanged.
- pReset asserted after 20 bits -> next cycle all outputs 0 and FSM IDLE; new start reloads the full CHAIN_LEN.
- CCFF_TAIL_READBACK_EN: model chain preloaded with 64 zeros, ccff_tail=0 for all bits -> readback_sig equals the CRC16-CCITT of 64 zero bits from init 0xFFFF.
